// File: rtl/stim_scheduler.sv
// stim_scheduler
//   Round-robin scheduler sharing one filter-under-test input between two
//   stb/ack stimulus sources. Sources are granted in bursts of up to BURST
//   samples while the other one is requesting. Each granted sample is
//   forwarded with a source tag on a stb/ack output. The block stops after
//   sample_limit samples; a limit of 0 means it never stops.
//
// State table
//   IDLE | not running; acks and output stb low; waits for enable
//   ARB  | picks the next source (owner first until its burst is used up)
//   READ | granted ack is high; sample and source tag are captured
//   SEND | output_z_stb held until output_z_ack; sample is counted there
//   DONE | limit reached; done high until enable drops
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   enable, sample_limit        run request, samples to forward (0 = no limit)
//   input_a/_stb/_ack           source A stream
//   input_b/_stb/_ack           source B stream
//   output_z/_stb/_ack/_src     forwarded stream; src 0 = A, 1 = B
//   sample_count, done          samples forwarded since run start, limit hit
module stim_scheduler #(
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [31:0]      sample_limit,
  input  logic [WIDTH-1:0] input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  input  logic [WIDTH-1:0] input_b,
  input  logic             input_b_stb,
  output logic             input_b_ack,
  output logic [WIDTH-1:0] output_z,
  output logic             output_z_stb,
  input  logic             output_z_ack,
  output logic             output_z_src,
  output logic [31:0]      sample_count,
  output logic             done
);

  localparam int BW = $clog2(BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_READ, S_SEND, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;   // 0 = A, 1 = B
  logic [BW-1:0]    burst_q, burst_d;
  logic [31:0]      limit_q, limit_d;
  logic [31:0]      count_q, count_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             z_stb_q, z_stb_d;
  logic             z_src_q, z_src_d;
  logic             done_q, done_d;

  logic             own_stb, oth_stb;
  logic             grant, grant_src;
  logic [31:0]      count_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      burst_q <= '0;
      limit_q <= '0;
      count_q <= '0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      z_q     <= '0;
      z_stb_q <= 1'b0;
      z_src_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      limit_q <= limit_d;
      count_q <= count_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      z_q     <= z_d;
      z_stb_q <= z_stb_d;
      z_src_q <= z_src_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    burst_d   = burst_q;
    limit_d   = limit_q;
    count_d   = count_q;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    z_d       = z_q;
    z_stb_d   = z_stb_q;
    z_src_d   = z_src_q;
    done_d    = done_q;
    grant     = 1'b0;
    grant_src = owner_q;
    own_stb   = owner_q ? input_b_stb : input_a_stb;
    oth_stb   = owner_q ? input_a_stb : input_b_stb;
    count_inc = count_q + 32'd1;

    case (state_q)
      S_IDLE: begin
        z_stb_d = 1'b0;
        if (enable) begin
          limit_d = sample_limit;
          count_d = '0;
          burst_d = '0;
          state_d = S_ARB;
        end
      end

      S_ARB: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (own_stb && (burst_q < BURST_MAX)) begin
          grant = 1'b1;
        end else if (oth_stb) begin
          grant     = 1'b1;
          grant_src = ~owner_q;
          owner_d   = ~owner_q;
          burst_d   = '0;
        end else if (own_stb) begin
          // Burst used up but nobody else wants the input: start a new burst.
          grant   = 1'b1;
          burst_d = '0;
        end
        if (grant) begin
          ack_a_d = ~grant_src;
          ack_b_d = grant_src;
          state_d = S_READ;
        end
      end

      // The granted source always ends up as owner, so owner_q selects it.
      S_READ: begin
        z_d     = owner_q ? input_b : input_a;
        z_src_d = owner_q;
        z_stb_d = 1'b1;
        state_d = S_SEND;
      end

      S_SEND: begin
        if (output_z_ack) begin
          z_stb_d = 1'b0;
          count_d = count_inc;
          if (burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
          if ((limit_q != 32'd0) && (count_inc == limit_q)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ARB;
          end
        end
      end

      S_DONE: begin
        done_d = 1'b1;
        if (!enable) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign input_a_ack  = ack_a_q;
  assign input_b_ack  = ack_b_q;
  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;
  assign output_z_src = z_src_q;
  assign sample_count = count_q;
  assign done         = done_q;

endmodule

// File: tb/tb_stim_scheduler.sv
// tb_stim_scheduler
//   Directed bench for stim_scheduler (WIDTH=32, BURST=2). Two queue-backed
//   sources hold stb while they have data and advance after an ack. A monitor
//   captures every forwarded sample and flags cycles with both acks high.
module tb_stim_scheduler;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] sample_limit;
  logic [31:0] input_a, input_b;
  logic        input_a_stb, input_b_stb;
  logic        input_a_ack, input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb, output_z_ack, output_z_src;
  logic [31:0] sample_count;
  logic        done;

  stim_scheduler #(.WIDTH(32), .BURST(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_limit (sample_limit),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack),
    .output_z_src (output_z_src),
    .sample_count (sample_count),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int dual_ack = 0;

  logic [31:0] a_q[$];
  logic [31:0] b_q[$];
  logic [31:0] cap_z[$];
  logic        cap_src[$];
  int          cap_cyc[$];
  logic        a_seen, b_seen;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_stb(input string tag, input int budget);
    int n = 0;
    while (!output_z_stb && n < budget) begin
      tick();
      n++;
    end
    check_val(tag, {31'd0, output_z_stb}, 32'd1);
  endtask

  task automatic clear_cap;
    cap_z.delete();
    cap_src.delete();
    cap_cyc.delete();
  endtask

  function automatic logic [31:0] cap_at(input int i);
    return (i < cap_z.size()) ? cap_z[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] src_at(input int i);
    return (i < cap_src.size()) ? {31'd0, cap_src[i]} : 32'hxxxx_xxxx;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && input_a_ack && input_b_ack) dual_ack++;
    if (rst && output_z_stb && output_z_ack) begin
      cap_z.push_back(output_z);
      cap_src.push_back(output_z_src);
      cap_cyc.push_back(cyc);
    end
  end

  // Source models: advance one sample after an observed ack pulse.
  initial begin
    a_seen = 1'b0;
    b_seen = 1'b0;
    input_a = '0;
    input_b = '0;
    input_a_stb = 1'b0;
    input_b_stb = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        a_seen = 1'b0;
        b_seen = 1'b0;
      end else begin
        if (a_seen && a_q.size() > 0) void'(a_q.pop_front());
        if (b_seen && b_q.size() > 0) void'(b_q.pop_front());
        a_seen = input_a_ack;
        b_seen = input_b_ack;
      end
      input_a_stb = (a_q.size() > 0);
      input_a     = (a_q.size() > 0) ? a_q[0] : '0;
      input_b_stb = (b_q.size() > 0);
      input_b     = (b_q.size() > 0) ? b_q[0] : '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_z2[8];
    logic [31:0] exp_s2[8];
    logic        ack_seen;
    logic [31:0] cnt_before;

    exp_z2 = '{32'd100, 32'd101, 32'd200, 32'd201, 32'd102, 32'd103, 32'd202, 32'd203};
    exp_s2 = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd1, 32'd1};

    rst = 1'b0;
    enable = 1'b0;
    sample_limit = '0;
    output_z_ack = 1'b1;
    tick();
    tick();
    check_val("rst_ack_a", {31'd0, input_a_ack}, 32'd0);
    check_val("rst_ack_b", {31'd0, input_b_ack}, 32'd0);
    check_val("rst_stb", {31'd0, output_z_stb}, 32'd0);
    check_val("rst_z", output_z, 32'd0);
    check_val("rst_src", {31'd0, output_z_src}, 32'd0);
    check_val("rst_count", sample_count, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    tick();

    // A streams 10,20,30 with limit 3 and ack tied high.
    a_q = '{32'd10, 32'd20, 32'd30};
    sample_limit = 32'd3;
    tick();
    clear_cap();
    enable = 1'b1;
    tick();
    check_val("t1_arb_ack", {31'd0, input_a_ack}, 32'd0);
    tick();
    check_val("t1_read_ack", {31'd0, input_a_ack}, 32'd1);
    check_val("t1_read_stb", {31'd0, output_z_stb}, 32'd0);
    tick();
    check_val("t1_send_stb", {31'd0, output_z_stb}, 32'd1);
    check_val("t1_send_z", output_z, 32'd10);
    check_val("t1_send_ack", {31'd0, input_a_ack}, 32'd0);
    wait_done("t1_done", 40);
    check_val("t1_ncap", cap_z.size(), 32'd3);
    check_val("t1_z0", cap_at(0), 32'd10);
    check_val("t1_z1", cap_at(1), 32'd20);
    check_val("t1_z2", cap_at(2), 32'd30);
    for (int i = 0; i < 3; i++) check_val("t1_src", src_at(i), 32'd0);
    check_val("t1_count", sample_count, 32'd3);
    enable = 1'b0;
    tick();
    check_val("t1_done_clr", {31'd0, done}, 32'd0);
    check_val("t1_count_hold", sample_count, 32'd3);

    // Both sources always valid, BURST=2, limit 8.
    a_q.delete();
    b_q.delete();
    for (int i = 0; i < 8; i++) begin
      a_q.push_back(32'd100 + 32'(i));
      b_q.push_back(32'd200 + 32'(i));
    end
    sample_limit = 32'd8;
    tick();
    clear_cap();
    dual_ack = 0;
    enable = 1'b1;
    wait_done("t2_done", 80);
    check_val("t2_ncap", cap_z.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_val("t2_z", cap_at(i), exp_z2[i]);
      check_val("t2_src", src_at(i), exp_s2[i]);
    end
    check_val("t2_dual_ack", 32'(dual_ack), 32'd0);
    check_val("t2_count", sample_count, 32'd8);
    enable = 1'b0;
    tick();

    // Only B valid, limit 5: back-to-back with no burst-expiry stall.
    a_q.delete();
    b_q.delete();
    for (int i = 0; i < 5; i++) b_q.push_back(32'd300 + 32'(i));
    sample_limit = 32'd5;
    tick();
    clear_cap();
    enable = 1'b1;
    wait_done("t3_done", 40);
    check_val("t3_ncap", cap_z.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check_val("t3_z", cap_at(i), 32'd300 + 32'(i));
      check_val("t3_src", src_at(i), 32'd1);
    end
    for (int i = 1; i < 5 && i < cap_cyc.size(); i++)
      check_val("t3_gap", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd3);
    check_val("t3_count", sample_count, 32'd5);
    enable = 1'b0;
    tick();

    // Downstream stalls for 7 cycles.
    a_q.delete();
    b_q.delete();
    a_q.push_back(32'h77);
    sample_limit = 32'd1;
    output_z_ack = 1'b0;
    tick();
    clear_cap();
    enable = 1'b1;
    wait_stb("t4_stb_rise", 10);
    for (int i = 0; i < 7; i++) begin
      check_val("t4_z", output_z, 32'h77);
      check_val("t4_src", {31'd0, output_z_src}, 32'd0);
      check_val("t4_stb", {31'd0, output_z_stb}, 32'd1);
      check_val("t4_in_ack", {30'd0, input_a_ack, input_b_ack}, 32'd0);
      check_val("t4_count", sample_count, 32'd0);
      tick();
    end
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    check_val("t4_count_ack", sample_count, 32'd1);
    check_val("t4_stb_clr", {31'd0, output_z_stb}, 32'd0);
    check_val("t4_done", {31'd0, done}, 32'd1);
    check_val("t4_ncap", cap_z.size(), 32'd1);

    // enable dropped during SEND with limit 0.
    enable = 1'b0;
    tick();
    check_val("t5_done_clr", {31'd0, done}, 32'd0);
    check_val("t5_count_hold", sample_count, 32'd1);
    a_q.push_back(32'h88);
    a_q.push_back(32'h99);
    sample_limit = 32'd0;
    tick();
    clear_cap();
    enable = 1'b1;
    wait_stb("t5_stb_rise", 10);
    enable = 1'b0;
    tick();
    tick();
    check_val("t5_stb_hold", {31'd0, output_z_stb}, 32'd1);
    check_val("t5_z_hold", output_z, 32'h88);
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    check_val("t5_count", sample_count, 32'd1);
    check_val("t5_stb_clr", {31'd0, output_z_stb}, 32'd0);
    ack_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ack_seen = ack_seen | input_a_ack | input_b_ack;
    end
    check_val("t5_no_ack", {31'd0, ack_seen}, 32'd0);
    check_val("t5_ncap", cap_z.size(), 32'd1);
    check_val("t5_z", cap_at(0), 32'h88);
    cnt_before = sample_count;
    check_val("t5_count_idle", cnt_before, 32'd1);
    enable = 1'b1;
    tick();
    check_val("t5_reenable_clr", sample_count, 32'd0);
    enable = 1'b0;
    tick();
    tick();

    // Reset asserted while a 0x55 sample sits in SEND.
    a_q.delete();
    b_q.delete();
    a_q = '{32'h55, 32'h55, 32'h55};
    b_q.push_back(32'hBB);
    tick();
    enable = 1'b1;
    wait_stb("t6_stb_rise", 10);
    check_val("t6_z_pre", output_z, 32'h55);
    rst = 1'b0;
    #1;
    check_val("t6_rst_stb", {31'd0, output_z_stb}, 32'd0);
    check_val("t6_rst_z", output_z, 32'd0);
    check_val("t6_rst_count", sample_count, 32'd0);
    tick();
    rst = 1'b1;
    wait_stb("t6_stb_again", 10);
    check_val("t6_z_post", output_z, 32'h55);
    check_val("t6_src_post", {31'd0, output_z_src}, 32'd0);
    enable = 1'b0;
    output_z_ack = 1'b1;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
